// File: rtl/peak_scan_pkg.sv
// Shared types, defaults and helpers for the peak scanner.
//   state_t  : scan FSM states
//   DEF_*    : default parameter values
//   mag_fold : ones'-complement magnitude fold of a sign-extended sample
package peak_scan_pkg;

  localparam int unsigned DEF_DW         = 48;
  localparam int unsigned DEF_NCH        = 4;
  localparam int unsigned DEF_WIN_CYC    = 150000;
  localparam int unsigned DEF_SETTLE_CYC = 4;

  // Working width of mag_fold; callers sign-extend samples up to it.
  localparam int unsigned FOLD_W = 64;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SELECT,
    ST_SETTLE,
    ST_MEASURE,
    ST_COMMIT
  } state_t;

  // For a negative value the MSB is 1, so ~x equals {1'b0, ~x[W-2:0]}.
  // This holds at any width after sign extension.
  function automatic logic [FOLD_W-1:0] mag_fold(input logic [FOLD_W-1:0] x);
    return x[FOLD_W-1] ? ~x : x;
  endfunction

endpackage

// File: rtl/peak_track.sv
// Magnitude register and running-max tracker for the selected channel.
//   clk, rst   : clock, synchronous active-low reset
//   sample     : raw two's-complement sample of the selected channel
//   clr        : force the running max to 0 at the next edge
//   upd        : let the registered magnitude update the running max
//   peak_nxt_c : running max including this cycle's update (combinational)
module peak_track
  import peak_scan_pkg::*;
#(
  parameter int unsigned DW = DEF_DW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] sample,
  input  logic          clr,
  input  logic          upd,
  output logic [DW-1:0] peak_nxt_c
);

  logic [FOLD_W-1:0] sample_ext;
  logic [DW-1:0]     mag_q;
  logic [DW-1:0]     peak_q;

  assign sample_ext = FOLD_W'($signed(sample));
  assign peak_nxt_c = (upd && (mag_q > peak_q)) ? mag_q : peak_q;

  // One-cycle magnitude pipeline and running max; clear wins over update.
  always_ff @(posedge clk) begin
    if (!rst) begin
      mag_q  <= '0;
      peak_q <= '0;
    end else begin
      mag_q  <= DW'(mag_fold(sample_ext));
      peak_q <= clr ? '0 : peak_nxt_c;
    end
  end

endmodule

// File: rtl/peak_scan_ctrl.sv
// Round-robin peak scanner: per enabled channel, settle, measure the peak
// magnitude over a fixed window, and commit it to a readable result bank.
//   clk, rst        : clock, synchronous active-low reset
//   en, ch_mask     : scan enable and per-channel enable (sampled at SELECT)
//   data_in         : NCH packed samples, channel k at [k*DW +: DW]
//   rd_req, rd_ch   : single-cycle read request
//   rd_ack, rd_data, rd_fresh : read response, one cycle after the request
//   cur_ch, busy, scan_done   : status
module peak_scan_ctrl
  import peak_scan_pkg::*;
#(
  parameter int unsigned DW         = DEF_DW,
  parameter int unsigned NCH        = DEF_NCH,
  parameter int unsigned WIN_CYC    = DEF_WIN_CYC,
  parameter int unsigned SETTLE_CYC = DEF_SETTLE_CYC
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic [NCH-1:0]          ch_mask,
  input  logic [NCH*DW-1:0]       data_in,
  input  logic                    rd_req,
  input  logic [$clog2(NCH)-1:0]  rd_ch,
  output logic                    rd_ack,
  output logic [DW-1:0]           rd_data,
  output logic                    rd_fresh,
  output logic [$clog2(NCH)-1:0]  cur_ch,
  output logic                    busy,
  output logic                    scan_done
);

  localparam int unsigned CHW     = $clog2(NCH);
  localparam int unsigned DIW     = $clog2(NCH * DW);
  localparam int unsigned CNT_MAX = (WIN_CYC > SETTLE_CYC) ? WIN_CYC : SETTLE_CYC;
  localparam int unsigned CW      = $clog2(CNT_MAX) + 1;
  localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYC - 1);
  localparam logic [CW-1:0] WIN_LAST    = CW'(WIN_CYC - 1);

  state_t           state_q, state_nxt;
  logic [CW-1:0]    cnt_q;
  logic [CHW-1:0]   rr_ptr_q;
  logic [NCH-1:0]   mask_q;
  logic             meas_q;
  logic [DW-1:0]    result_q [NCH];
  logic [NCH-1:0]   fresh_q;

  logic [CHW-1:0]   sel_ch_c;
  logic             sel_found_c;
  logic [CHW-1:0]   hi_ch_c;
  logic [DIW-1:0]   base_c;
  logic [DW-1:0]    sample_c;
  logic [DW-1:0]    peak_nxt_c;

  assign base_c   = DIW'(cur_ch) * DIW'(DW);
  assign sample_c = data_in[base_c +: DW];

  // The magnitude register adds a cycle, so updates run one cycle behind
  // MEASURE; the last window sample lands in the COMMIT cycle via peak_nxt_c.
  peak_track #(.DW(DW)) u_track (
    .clk        (clk),
    .rst        (rst),
    .sample     (sample_c),
    .clr        (state_q != ST_MEASURE),
    .upd        (meas_q),
    .peak_nxt_c (peak_nxt_c)
  );

  // Next set mask bit after the last committed channel; smallest offset wins.
  always_comb begin
    sel_found_c = 1'b0;
    sel_ch_c    = '0;
    for (int i = int'(NCH); i >= 1; i--) begin
      if (ch_mask[CHW'((int'(rr_ptr_q) + i) % int'(NCH))]) begin
        sel_found_c = 1'b1;
        sel_ch_c    = CHW'((int'(rr_ptr_q) + i) % int'(NCH));
      end
    end
  end

  // Highest channel of the round's mask, which marks the end of a round.
  always_comb begin
    hi_ch_c = '0;
    for (int unsigned c = 0; c < NCH; c++) begin
      if (mask_q[CHW'(c)]) hi_ch_c = CHW'(c);
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state_q;
    case (state_q)
      ST_IDLE:    if (en && |ch_mask) state_nxt = ST_SELECT;
      ST_SELECT:  state_nxt = sel_found_c ? ST_SETTLE : ST_IDLE;
      ST_SETTLE:  if (cnt_q == SETTLE_LAST) state_nxt = ST_MEASURE;
      ST_MEASURE: if (cnt_q == WIN_LAST) state_nxt = ST_COMMIT;
      ST_COMMIT:  state_nxt = (en && |ch_mask) ? ST_SELECT : ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  // State, counters, result bank and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      rr_ptr_q  <= CHW'(NCH - 1);
      mask_q    <= '0;
      meas_q    <= 1'b0;
      fresh_q   <= '0;
      for (int unsigned k = 0; k < NCH; k++) result_q[CHW'(k)] <= '0;
      cur_ch    <= '0;
      busy      <= 1'b0;
      scan_done <= 1'b0;
      rd_ack    <= 1'b0;
      rd_data   <= '0;
      rd_fresh  <= 1'b0;
    end else begin
      state_q   <= state_nxt;
      busy      <= (state_nxt != ST_IDLE);
      meas_q    <= (state_q == ST_MEASURE);
      scan_done <= (state_q == ST_MEASURE) && (cnt_q == WIN_LAST) && (cur_ch == hi_ch_c);

      if ((state_q == ST_SETTLE || state_q == ST_MEASURE) && state_nxt == state_q)
        cnt_q <= cnt_q + CW'(1);
      else
        cnt_q <= '0;

      if (state_q == ST_SELECT) begin
        mask_q <= ch_mask;
        if (sel_found_c) cur_ch <= sel_ch_c;
      end

      if (state_q == ST_COMMIT) begin
        result_q[cur_ch] <= peak_nxt_c;
        rr_ptr_q         <= cur_ch;
      end

      // Read returns pre-edge values; a same-cycle commit leaves fresh set.
      rd_ack <= rd_req;
      if (rd_req) begin
        rd_data  <= result_q[rd_ch];
        rd_fresh <= fresh_q[rd_ch];
      end
      for (int unsigned k = 0; k < NCH; k++) begin
        if (state_q == ST_COMMIT && cur_ch == CHW'(k))
          fresh_q[CHW'(k)] <= 1'b1;
        else if (rd_req && rd_ch == CHW'(k))
          fresh_q[CHW'(k)] <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_peak_scan_ctrl.sv
// Bench for peak_scan_ctrl: directed scenarios plus a randomized stretch,
// checked every cycle against a period-position reference model.
module tb_peak_scan_ctrl;

  localparam int DW  = 16;
  localparam int NCH = 4;
  localparam int W   = 16;
  localparam int S   = 2;
  localparam int P   = S + W + 2;

  logic              clk;
  logic              rst;
  logic              en;
  logic [NCH-1:0]    ch_mask;
  logic [NCH*DW-1:0] data_in;
  logic              rd_req;
  logic [1:0]        rd_ch;
  logic              rd_ack;
  logic [DW-1:0]     rd_data;
  logic              rd_fresh;
  logic [1:0]        cur_ch;
  logic              busy;
  logic              scan_done;

  logic signed [DW-1:0] din [NCH];

  peak_scan_ctrl #(.DW(DW), .NCH(NCH), .WIN_CYC(W), .SETTLE_CYC(S)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .ch_mask   (ch_mask),
    .data_in   (data_in),
    .rd_req    (rd_req),
    .rd_ch     (rd_ch),
    .rd_ack    (rd_ack),
    .rd_data   (rd_data),
    .rd_fresh  (rd_fresh),
    .cur_ch    (cur_ch),
    .busy      (busy),
    .scan_done (scan_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    data_in = '0;
    for (int k = 0; k < NCH; k++) data_in[k*DW +: DW] = din[k];
  end

  // Reference model: m_pos is the position inside a channel period
  // (0 select, 1..S settle, S+1..S+W window, P-1 commit).
  bit            m_idle;
  int            m_pos, m_ch, m_last, m_peak;
  logic [NCH-1:0] m_mask;
  logic [DW-1:0] m_res [NCH];
  bit            m_fresh [NCH];
  logic          exp_ack, exp_fresh, exp_done, exp_busy;
  logic [DW-1:0] exp_data;
  logic [1:0]    exp_cur;

  int n_checks, n_pass, cyc;
  int done_q[$];
  bit ch1_shape;

  function automatic int top_bit(input logic [NCH-1:0] m);
    int r;
    r = -1;
    for (int c = 0; c < NCH; c++) if (m[c]) r = c;
    return r;
  endfunction

  function automatic bit at_pos(input int ch, input int pos);
    return !m_idle && m_ch == ch && m_pos == pos;
  endfunction

  task automatic model_edge();
    int nxt, v;
    if (!rst) begin
      m_idle = 1; m_pos = 0; m_ch = 0; m_last = NCH - 1; m_peak = 0; m_mask = '0;
      for (int k = 0; k < NCH; k++) begin m_res[k] = '0; m_fresh[k] = 0; end
      exp_ack = 0; exp_data = '0; exp_fresh = 0; exp_done = 0; exp_busy = 0; exp_cur = '0;
      return;
    end
    exp_ack  = rd_req;
    exp_done = 0;
    if (rd_req) begin
      exp_data  = m_res[rd_ch];
      exp_fresh = m_fresh[rd_ch];
      m_fresh[rd_ch] = 0;
    end
    if (m_idle) begin
      if (en && ch_mask != '0) begin m_idle = 0; m_pos = 0; end
    end else if (m_pos == 0) begin
      m_mask = ch_mask;
      nxt = -1;
      for (int i = 1; i <= NCH; i++)
        if (nxt < 0 && m_mask[(m_last + i) % NCH]) nxt = (m_last + i) % NCH;
      if (nxt < 0) m_idle = 1;
      else begin m_ch = nxt; m_peak = 0; m_pos = 1; end
    end else if (m_pos <= S) begin
      m_pos++;
    end else if (m_pos <= S + W) begin
      v = int'(din[m_ch]);
      if (v < 0) v = -v - 1;
      if (v > m_peak) m_peak = v;
      if (m_pos == S + W) exp_done = (m_ch == top_bit(m_mask));
      m_pos++;
    end else begin
      m_res[m_ch]   = 16'(m_peak);
      m_fresh[m_ch] = 1;
      m_last        = m_ch;
      if (en && ch_mask != '0) m_pos = 0;
      else m_idle = 1;
    end
    exp_busy = !m_idle;
    exp_cur  = 2'(m_ch);
  endtask

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  task automatic timeout_fail(input string tag);
    n_checks++;
    $error("FAIL %s: observed no event expected event within bound (cycle %0d)", tag, cyc);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    cyc++;
    chk("busy", busy, exp_busy);
    chk("cur_ch", cur_ch, exp_cur);
    chk("scan_done", scan_done, exp_done);
    chk("rd_ack", rd_ack, exp_ack);
    chk("rd_data", rd_data, exp_data);
    chk("rd_fresh", rd_fresh, exp_fresh);
    if (scan_done) done_q.push_back(cyc);
    rd_req = 1'b0;
    if (ch1_shape)
      din[1] = (at_pos(1, m_pos) && m_pos >= S + 1 && m_pos <= S + W) ? 16'sd3 : 16'sd1000;
  endtask

  task automatic read_ch(input int ch);
    rd_req = 1'b1;
    rd_ch  = 2'(ch);
    step();
  endtask

  initial begin
    int n;
    n_checks = 0; n_pass = 0; cyc = 0; ch1_shape = 0;
    rst = 1'b0; en = 1'b0; ch_mask = '0; rd_req = 1'b0; rd_ch = '0;
    for (int k = 0; k < NCH; k++) din[k] = '0;

    // Reset state.
    repeat (3) step();
    chk("rst_busy", busy, 1'b0);
    chk("rst_cur_ch", cur_ch, 2'd0);
    chk("rst_rd_data", rd_data, 16'd0);
    chk("rst_scan_done", scan_done, 1'b0);
    rst = 1'b1;

    // Enabled with an empty mask: stays idle.
    en = 1'b1;
    repeat (5) step();
    chk("empty_mask_idle", busy, 1'b0);

    // ch0 = -5, ch2 = 7; read ch2 in its commit cycle, then twice more.
    ch_mask = 4'b0101;
    din[0] = -16'sd5;
    din[2] = 16'sd7;
    n = 0;
    while (!at_pos(2, P - 1) && n < 100) begin step(); n++; end
    if (!at_pos(2, P - 1)) timeout_fail("wait_ch2_commit");
    chk("done_at_ch2_commit", scan_done, 1'b1);
    read_ch(2);
    chk("commit_rd_old", rd_data, 16'd0);
    chk("commit_rd_fresh", rd_fresh, 1'b0);
    read_ch(2);
    chk("ch2_peak", rd_data, 16'd7);
    chk("ch2_fresh", rd_fresh, 1'b1);
    read_ch(2);
    chk("ch2_fresh_cleared", rd_fresh, 1'b0);
    read_ch(0);
    chk("ch0_peak", rd_data, 16'd4);
    chk("ch0_fresh", rd_fresh, 1'b1);
    read_ch(1);
    chk("unmeasured_ch1", rd_data, 16'd0);
    chk("unmeasured_ch1_fresh", rd_fresh, 1'b0);

    // ch1: large value while settling, small while measuring.
    ch_mask = 4'b0010;
    ch1_shape = 1;
    n = 0;
    while (!at_pos(1, P - 1) && n < 200) begin step(); n++; end
    if (!at_pos(1, P - 1)) timeout_fail("wait_ch1_commit");
    step();
    ch1_shape = 0;
    read_ch(1);
    chk("settle_discard", rd_data, 16'd3);

    // en dropped mid-window: the window completes, then idle.
    ch_mask = 4'b0001;
    din[0] = 16'sd1234;
    n = 0;
    while (!at_pos(0, S + 1 + 5) && n < 200) begin step(); n++; end
    if (!at_pos(0, S + 1 + 5)) timeout_fail("wait_ch0_win5");
    en = 1'b0;
    n = 0;
    while (!m_idle && n < 40) begin step(); n++; end
    if (!m_idle) timeout_fail("wait_idle_after_en");
    step();
    chk("en_drop_idle", busy, 1'b0);
    read_ch(0);
    chk("en_drop_commit", rd_data, 16'd1234);
    chk("en_drop_fresh", rd_fresh, 1'b1);

    // Randomized stretch.
    for (int t = 0; t < 600; t++) begin
      if (t % 40 == 0) ch_mask = 4'($urandom_range(0, 15));
      if (t % 25 == 0) en = ($urandom_range(0, 5) != 0);
      for (int k = 0; k < NCH; k++) din[k] = 16'($urandom);
      if ($urandom_range(0, 3) == 0) begin
        rd_req = 1'b1;
        rd_ch  = 2'($urandom_range(0, 3));
      end
      step();
    end

    // Reset during measure cycle 8.
    en = 1'b1;
    ch_mask = 4'b1111;
    n = 0;
    while (!(!m_idle && m_pos == S + 1 + 8) && n < 200) begin step(); n++; end
    if (!(!m_idle && m_pos == S + 1 + 8)) timeout_fail("wait_meas8");
    rst = 1'b0;
    en = 1'b0;
    step();
    rst = 1'b1;
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_cur_ch", cur_ch, 2'd0);
    for (int k = 0; k < NCH; k++) begin
      read_ch(k);
      chk("midrst_rd_data", rd_data, 16'd0);
      chk("midrst_rd_fresh", rd_fresh, 1'b0);
    end
    en = 1'b1;
    n = 0;
    while (!(!m_idle && m_pos == 1) && n < 20) begin step(); n++; end
    if (!(!m_idle && m_pos == 1)) timeout_fail("wait_first_select");
    chk("restart_ch0", cur_ch, 2'd0);

    // Empty mask drains to idle; then ch3 alone repeats every period.
    ch_mask = 4'b0000;
    n = 0;
    while (!m_idle && n < 60) begin step(); n++; end
    if (!m_idle) timeout_fail("wait_idle_empty");
    repeat (10) step();
    chk("empty_mask_stays_idle", busy, 1'b0);
    ch_mask = 4'b1000;
    done_q.delete();
    repeat (90) step();
    chk("ch3_done_count_ge3", done_q.size() >= 3, 1'b1);
    for (int i = 1; i < done_q.size(); i++)
      chk("ch3_done_period", done_q[i] - done_q[i-1], P);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/peak_scan_ctrl.md
PEAK_SCAN_CTRL -- requirements
Module: peak_scan_ctrl

Interface
REQ-001 SHALL have parameter DW, default 48, sample width (two's complement).
REQ-002 SHALL have parameter NCH, default 4, number of input channels.
REQ-003 SHALL have parameter WIN_CYC, default 150000, measurement window in clocks (1 ms at 150 MHz).
REQ-004 SHALL have parameter SETTLE_CYC, default 4, discard cycles after a channel switch.
REQ-005 SHALL have the port `clk`: input, 1 bit, single clock; all logic on its rising edge.
REQ-006 SHALL have the port `rst`: input, 1 bit, synchronous, active-low reset.
REQ-007 SHALL have the port `en`: input, 1 bit, scanning enable.
REQ-008 SHALL have the port `ch_mask`: input, NCH bits, per-channel scan enable.
REQ-009 SHALL have the port `data_in`: input, NCH*DW bits, channel k at bits [k*DW +: DW].
REQ-010 SHALL have the port `rd_req`: input, 1 bit, single-cycle read request.
REQ-011 SHALL have the port `rd_ch`: input, clog2(NCH) bits, channel to read, sampled with rd_req.
REQ-012 SHALL have the port `rd_ack`: output, 1 bit, one-cycle read-response strobe.
REQ-013 SHALL have the port `rd_data`: output, DW bits, stored peak of the requested channel.
REQ-014 SHALL have the port `rd_fresh`: output, 1 bit, result committed since the last read of that channel.
REQ-015 SHALL have the port `cur_ch`: output, clog2(NCH) bits, channel currently selected.
REQ-016 SHALL have the port `busy`: output, 1 bit, FSM not in IDLE.
REQ-017 SHALL have the port `scan_done`: output, 1 bit, one-cycle pulse at the end of a full round.

Function
REQ-018 SHALL compute the magnitude, registered one cycle: negative x -> {1'b0, ~x[DW-2:0]}, non-negative x -> x unchanged.
REQ-019 SHALL implement FSM states IDLE, SELECT, SETTLE, MEASURE, COMMIT.
REQ-020 IDLE: en=1 and ch_mask!=0 -> SELECT; otherwise stay in IDLE.
REQ-021 SELECT (1 cycle): sample ch_mask and pick the next set bit round-robin after the last committed channel, wrapping at NCH-1 -> 0; update cur_ch; go to SETTLE.
REQ-022 SETTLE: hold the running max at 0 for SETTLE_CYC cycles; then go to MEASURE.
REQ-023 MEASURE: for WIN_CYC cycles, running max <= mag when mag > running max (unsigned strict compare); then go to COMMIT.
REQ-024 COMMIT (1 cycle): result[cur_ch] <= running max, fresh[cur_ch] <= 1, and the running max clears.
REQ-025 After COMMIT: go to SELECT if en=1 and the currently sampled ch_mask!=0; otherwise go to IDLE.
REQ-026 Per-channel period SHALL be exactly SETTLE_CYC + WIN_CYC + 2 cycles.
REQ-027 scan_done SHALL pulse in the COMMIT cycle of the highest-indexed channel in the ch_mask sampled at SELECT.
REQ-028 en deasserted mid-window SHALL NOT abort the window; the current channel completes its COMMIT.
REQ-029 ch_mask changes SHALL take effect only at the next SELECT.
REQ-030 Read: rd_req at cycle t -> rd_ack=1 at t+1, with rd_data=result[rd_ch] and rd_fresh=fresh[rd_ch] as of cycle t; then fresh[rd_ch] clears.
REQ-031 Read of a channel in the same cycle as its COMMIT SHALL return the old value with rd_fresh as of cycle t, and fresh SHALL end at 1.
REQ-032 A masked or never-measured channel SHALL read its stored value (0 after reset) with rd_fresh=0.
REQ-033 busy SHALL be 0 in IDLE and 1 in all other states.

Reset
REQ-034 rst=0 at any clock edge SHALL force: FSM to IDLE, all results 0, all fresh flags 0, running max 0, counters 0, cur_ch 0, round-robin pointer to NCH-1 (so channel 0 is chosen first), rd_ack 0, rd_data 0, rd_fresh 0, scan_done 0.
REQ-035 Reset asserted mid-window SHALL discard the partial peak with no COMMIT.

Structure
REQ-036 Package peak_scan_pkg SHALL hold the FSM state enum, default DW/NCH/WIN_CYC/SETTLE_CYC, and the magnitude-fold function.
REQ-037 One sub-module, peak_track, SHALL hold the magnitude register and running max, with clear and update controls.
REQ-038 Counter widths SHALL be clog2 of the larger of WIN_CYC and SETTLE_CYC, plus 1.

Verification (WIN_CYC=16, SETTLE_CYC=2, NCH=4)
REQ-039 en=1, mask=4'b0101, ch0 input steady at -5, ch2 steady at 7 -> commits ch0=4 then ch2=7, 20 cycles apart; scan_done pulses at ch2's COMMIT.
REQ-040 ch1 input =1000 during SETTLE, 3 during MEASURE -> result[1]=3.
REQ-041 rd_req, rd_ch=2 issued in ch2's COMMIT cycle -> next cycle rd_data=old value; a second read then returns 7 with rd_fresh=1; a third read returns rd_fresh=0.
REQ-042 en dropped at window cycle 5 -> the window completes, COMMIT occurs, FSM goes to IDLE, busy=0.
REQ-043 rst=0 at MEASURE cycle 8 -> the next cycle shows IDLE, all reads return 0 with rd_fresh=0, and the next scan starts at ch0.
REQ-044 en=1, mask=0 -> FSM stays in IDLE; mask set to 4'b1000 -> ch3 is measured repeatedly and scan_done pulses every 20 cycles.
